// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB-Lite arbiter: registered one-hot grant, address/data-phase
// owner tracking, locked-sequence hold and a per-tenure beat limit.
module ahb_rr_arbiter #(
    parameter int NM      = 4,
    parameter int MW      = 2,
    parameter int DEF_M   = 0,
    parameter int MAXBEAT = 16,
    parameter int TW      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NM-1:0] hreq_i,
    input  logic [NM-1:0] hlock_i,
    input  logic [1:0]    htrans_i,
    input  logic          hready_i,
    output logic [NM-1:0] hgrant_o,
    output logic [MW-1:0] hmaster_o,
    output logic [MW-1:0] hmaster_data_o,
    output logic          hmastlock_o
);

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [NM-1:0] ONE_HOT_0 = {{(NM-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] DEF_IDX   = MW'(DEF_M);
    localparam logic [TW-1:0] MAX_T     = TW'(MAXBEAT);

    logic [NM-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0] hmaster_q, hmaster_data_q;
    logic          hmastlock_q;
    logic [TW-1:0] tenure_q, tenure_d;

    logic [MW-1:0] g;
    logic [MW-1:0] target;
    logic          arb_ok;
    htrans_e       htrans;

    assign htrans = htrans_e'(htrans_i);

    // NOTE: every always_comb variable gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        g = '0;
        for (int i = 0; i < NM; i++) begin
            if (hgrant_q[i]) g = MW'(i);
        end
    end

    // Arbitrate only at a burst boundary, never inside a locked sequence.
    assign arb_ok = hready_i && !hlock_i[g]
                 && (htrans != HT_BUSY) && (htrans != HT_SEQ)
                 && ((htrans == HT_IDLE) || !hreq_i[g] || (tenure_q == MAX_T));

    always_comb begin
        logic          found;
        logic [MW-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        target = hreq_i[g] ? g : DEF_IDX;
        for (int k = 1; k < NM; k++) begin
            idx = MW'((int'(g) + k) % NM);
            if (!found && hreq_i[idx]) begin
                found  = 1'b1;
                target = idx;
            end
        end
        hgrant_d = arb_ok ? (ONE_HOT_0 << target) : hgrant_q;
    end

    always_comb begin
        tenure_d = tenure_q;
        if (hgrant_d != hgrant_q) begin
            tenure_d = '0;
        end else if (hready_i && (htrans == HT_NONSEQ || htrans == HT_SEQ)
                     && tenure_q != MAX_T) begin
            tenure_d = tenure_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hgrant_q       <= ONE_HOT_0 << DEF_IDX;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            hmastlock_q    <= 1'b0;
            tenure_q       <= '0;
        end else begin
            hgrant_q <= hgrant_d;
            tenure_q <= tenure_d;
            if (hready_i) begin
                hmaster_data_q <= hmaster_q;
                hmaster_q      <= g;
                hmastlock_q    <= hlock_i[g];
            end
        end
    end

    assign hgrant_o       = hgrant_q;
    assign hmaster_o      = hmaster_q;
    assign hmaster_data_o = hmaster_data_q;
    assign hmastlock_o    = hmastlock_q;

endmodule
